// File: rtl/frvp_spi_reg_pkg.sv
// Shared types and helpers for the double-buffered SPI control register.
package frvp_spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOAD    = 2'd2
    } state_t;

    function automatic int unsigned strb_width(input int unsigned width);
        return width / 8;
    endfunction

    // Legal register widths are whole bytes, at least one byte.
    function automatic bit width_ok(input int unsigned width);
        return (width >= 8) && ((width % 8) == 0);
    endfunction

endpackage

// File: rtl/frvp_spi_strb_reg.sv
// Byte-strobed register with asynchronous active-low reset to RESET_VALUE.
module frvp_spi_strb_reg
    import frvp_spi_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [strb_width(WIDTH)-1:0]  strb,
    input  logic [WIDTH-1:0]              data,
    output logic [WIDTH-1:0]              q
);

    localparam int unsigned SW = strb_width(WIDTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VALUE;
        end else begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (strb[i]) begin
                    q[8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/frvp_spi_shadow_reg_vec.sv
// Double-buffered SPI control register: shadow written by software, active
// copy loaded from shadow only after a commit observes the engine idle.
module frvp_spi_shadow_reg_vec
    import frvp_spi_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          io_wr_en,
    input  logic [strb_width(WIDTH)-1:0]  io_wr_strb,
    input  logic [WIDTH-1:0]              io_wr_data,
    input  logic                          io_commit_req,
    input  logic                          io_abort,
    input  logic                          io_idle,
    output logic [WIDTH-1:0]              io_q,
    output logic [WIDTH-1:0]              io_shadow,
    output logic                          io_pending,
    output logic                          io_commit_done
);

    localparam int unsigned SW = strb_width(WIDTH);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("frvp_spi_shadow_reg_vec: WIDTH must be a multiple of 8, minimum 8");
    end

    state_t           state;
    logic             pending_r;
    logic             done_r;
    logic             load_c;
    logic [SW-1:0]    sh_strb;
    logic [WIDTH-1:0] sh_data;
    logic [SW-1:0]    act_strb;
    logic [WIDTH-1:0] shadow_next;

    // Abort beats load beats write; the load captures any same-cycle write.
    always_comb begin
        load_c      = (state == LOAD) && !io_abort;
        shadow_next = io_shadow;
        for (int unsigned i = 0; i < SW; i++) begin
            if (io_wr_en && io_wr_strb[i]) begin
                shadow_next[8*i +: 8] = io_wr_data[8*i +: 8];
            end
        end
        if (io_abort) begin
            sh_strb = '1;
            sh_data = io_q;
        end else begin
            sh_strb = io_wr_en ? io_wr_strb : '0;
            sh_data = io_wr_data;
        end
        act_strb = load_c ? '1 : '0;
    end

    frvp_spi_strb_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_shadow (
        .clock   (clock),
        .reset_n (reset_n),
        .strb    (sh_strb),
        .data    (sh_data),
        .q       (io_shadow)
    );

    frvp_spi_strb_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_active (
        .clock   (clock),
        .reset_n (reset_n),
        .strb    (act_strb),
        .data    (shadow_next),
        .q       (io_q)
    );

    // Commit handshake; pending and done are registered alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pending_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= load_c;
            case (state)
                IDLE: begin
                    if (io_commit_req && !io_abort) begin
                        state     <= PENDING;
                        pending_r <= 1'b1;
                    end
                end
                PENDING: begin
                    if (io_abort) begin
                        state     <= IDLE;
                        pending_r <= 1'b0;
                    end else if (io_idle) begin
                        state     <= LOAD;
                        pending_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (io_commit_req && !io_abort) begin
                        state     <= PENDING;
                        pending_r <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        pending_r <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign io_pending     = pending_r;
    assign io_commit_done = done_r;

endmodule
